// File: rtl/irst_fetch_unit.sv
// irst_fetch_unit
//   Instruction fetch PC generator with a built-in instruction-memory
//   reset/test (IRST) sweep engine.
//
//   FUNC : normal fetch, PC advances by 1 or by a signed branch offset.
//   FTI  : read sweep over addresses 0..irst_limit, pc = {0, sweep address}.
//   MIS  : write sweep over the same range, pc = {1, sweep address},
//          write_en asserted on every unstalled cycle.
//   DONE : sweep finished, waits for irst_start to drop.
//
//   Configuration macro: IRST_SHADOW_PC_EN
//     defined   -> PC is saved on entry to the sweep and restored on exit.
//     undefined -> PC restarts from 0 after the sweep; no shadow register.
module irst_fetch_unit #(
  parameter int PC_WIDTH     = 8,
  parameter int OFFSET_WIDTH = 6,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic                    irst_start,
  input  logic [PC_WIDTH-2:0]     irst_limit,
  input  logic [CNT_WIDTH-1:0]    irst_passes,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    write_en,
  output logic                    irst_busy,
  output logic                    irst_done,
  output logic [CNT_WIDTH-1:0]    pass_count
);

  // Sweep address covers the lower half of the address space; the top
  // pc bit selects read (FTI) or write (MIS) half.
  localparam int SW_WIDTH = PC_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_FUNC = 2'd0,
    ST_FTI  = 2'd1,
    ST_MIS  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_reg_q, pc_reg_d;
  logic [SW_WIDTH-1:0]   sweep_q, sweep_d;
  logic [CNT_WIDTH-1:0]  pass_q, pass_d;

`ifdef IRST_SHADOW_PC_EN
  logic [PC_WIDTH-1:0]   shadow_q, shadow_d;
`endif

  // Derived values used by the next-state logic.
  logic [PC_WIDTH-1:0]   branch_ext;
  logic [PC_WIDTH-1:0]   pc_func_next;
  logic [SW_WIDTH-1:0]   sweep_inc;
  logic                  sweep_end;
  logic                  pass_more;
  logic                  pass_sat;
  logic [PC_WIDTH-1:0]   pc_restore;

  // Sign-extend the branch offset and form the functional next PC.
  always_comb begin
    branch_ext   = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}},
                    branch_offset};
    pc_func_next = branch_taken ? (pc_reg_q + branch_ext)
                                : (pc_reg_q + PC_WIDTH'(1));
  end

  // Sweep bookkeeping: limit and pass target are compared live every cycle.
  always_comb begin
    sweep_inc = sweep_q + SW_WIDTH'(1);
    sweep_end = (sweep_q == irst_limit);
    pass_more = (pass_q < irst_passes);
    pass_sat  = &pass_q;
  end

  // Value loaded into the PC when leaving DONE.
`ifdef IRST_SHADOW_PC_EN
  always_comb begin
    pc_restore = shadow_q;
  end
`else
  always_comb begin
    pc_restore = '0;
  end
`endif

  // Next-state logic: a stall freezes every register in every state.
  always_comb begin
    state_d  = state_q;
    pc_reg_d = pc_reg_q;
    sweep_d  = sweep_q;
    pass_d   = pass_q;
`ifdef IRST_SHADOW_PC_EN
    shadow_d = shadow_q;
`endif
    if (!stall) begin
      unique case (state_q)
        ST_FUNC: begin
          if (fetch_en) begin
            pc_reg_d = pc_func_next;
          end
          if (irst_start) begin
            state_d = ST_FTI;
            sweep_d = '0;
            pass_d  = '0;
`ifdef IRST_SHADOW_PC_EN
            shadow_d = pc_reg_q;
`endif
          end
        end
        ST_FTI: begin
          if (sweep_end) begin
            sweep_d = '0;
            state_d = pass_more ? ST_MIS : ST_DONE;
          end else begin
            sweep_d = sweep_inc;
          end
        end
        ST_MIS: begin
          if (sweep_end) begin
            sweep_d = '0;
            state_d = ST_FTI;
            if (!pass_sat) begin
              pass_d = pass_q + CNT_WIDTH'(1);
            end
          end else begin
            sweep_d = sweep_inc;
          end
        end
        ST_DONE: begin
          if (!irst_start) begin
            state_d  = ST_FUNC;
            pc_reg_d = pc_restore;
          end
        end
        default: begin
          state_d = ST_FUNC;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FUNC;
      pc_reg_q <= '0;
      sweep_q  <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_reg_q <= pc_reg_d;
      sweep_q  <= sweep_d;
      pass_q   <= pass_d;
    end
  end

`ifdef IRST_SHADOW_PC_EN
  // Shadow PC register, saved on sweep entry and cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  // Output decode: pc mux, write strobe and status flags from state.
  always_comb begin
    pc        = pc_reg_q;
    write_en  = 1'b0;
    irst_busy = 1'b0;
    irst_done = 1'b0;
    unique case (state_q)
      ST_FUNC: begin
        pc = pc_reg_q;
      end
      ST_FTI: begin
        pc        = {1'b0, sweep_q};
        irst_busy = 1'b1;
      end
      ST_MIS: begin
        pc        = {1'b1, sweep_q};
        irst_busy = 1'b1;
        write_en  = ~stall;
      end
      ST_DONE: begin
        pc        = pc_reg_q;
        irst_done = 1'b1;
      end
      default: begin
        pc = pc_reg_q;
      end
    endcase
  end

  assign pass_count = pass_q;

endmodule

// File: tb/tb_irst_fetch_unit.sv
// Testbench for irst_fetch_unit: directed scenarios plus a randomized run,
// all checked against a behavioural model of the fetch/sweep rules.
module tb_irst_fetch_unit;

  localparam int PCW = 8;
  localparam int OFW = 6;
  localparam int CW  = 6;

  logic           clk;
  logic           rst_n;
  logic           fetch_en;
  logic           stall;
  logic           branch_taken;
  logic [OFW-1:0] branch_offset;
  logic           irst_start;
  logic [PCW-2:0] irst_limit;
  logic [CW-1:0]  irst_passes;
  logic [PCW-1:0] pc;
  logic           write_en;
  logic           irst_busy;
  logic           irst_done;
  logic [CW-1:0]  pass_count;

  irst_fetch_unit #(
    .PC_WIDTH    (PCW),
    .OFFSET_WIDTH(OFW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .irst_start   (irst_start),
    .irst_limit   (irst_limit),
    .irst_passes  (irst_passes),
    .pc           (pc),
    .write_en     (write_en),
    .irst_busy    (irst_busy),
    .irst_done    (irst_done),
    .pass_count   (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Activity: 0 = fetching, 1 = reading sweep, 2 = writing sweep, 3 = finished.
  int m_act;
  int m_pc;
  int m_addr;
  int m_passes;
  int m_saved_pc;

  function automatic void model_reset();
    m_act = 0; m_pc = 0; m_addr = 0; m_passes = 0; m_saved_pc = 0;
  endfunction

  function automatic void model_advance();
    int off;
    int old_pc;
    if (stall) return;
    case (m_act)
      0: begin
        old_pc = m_pc;
        if (fetch_en) begin
          off = int'(branch_offset);
          if (off >= (1 << (OFW - 1))) off -= (1 << OFW);
          m_pc = branch_taken ? ((m_pc + off) & ((1 << PCW) - 1))
                              : ((m_pc + 1) % (1 << PCW));
        end
        if (irst_start) begin
          m_saved_pc = old_pc;
          m_act = 1; m_addr = 0; m_passes = 0;
        end
      end
      1, 2: begin
        if (m_addr == int'(irst_limit)) begin
          m_addr = 0;
          if (m_act == 1) begin
            m_act = (m_passes < int'(irst_passes)) ? 2 : 3;
          end else begin
            m_act = 1;
            if (m_passes < (1 << CW) - 1) m_passes++;
          end
        end else begin
          m_addr = (m_addr + 1) % (1 << (PCW - 1));
        end
      end
      default: begin
        if (!irst_start) begin
          m_act = 0;
`ifdef IRST_SHADOW_PC_EN
          m_pc = m_saved_pc;
`else
          m_pc = 0;
`endif
        end
      end
    endcase
  endfunction

  function automatic int model_pc();
    if (m_act == 1) return m_addr;
    if (m_act == 2) return (1 << (PCW - 1)) + m_addr;
    return m_pc;
  endfunction

  // One cycle: inputs were set at the falling edge; check, then clock.
  task automatic step();
    #1;
    check_eq("pc",       32'(pc),         32'(model_pc()));
    check_eq("write_en", 32'(write_en),   32'((m_act == 2) && !stall));
    check_eq("busy",     32'(irst_busy),  32'((m_act == 1) || (m_act == 2)));
    check_eq("done",     32'(irst_done),  32'(m_act == 3));
    check_eq("passes",   32'(pass_count), 32'(m_passes));
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_en = 0; stall = 0; branch_taken = 0; branch_offset = '0;
    irst_start = 0; irst_limit = '0; irst_passes = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq[$];

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pc",   32'(pc),         32'h0);
    check_eq("rst_we",   32'(write_en),   32'h0);
    check_eq("rst_busy", 32'(irst_busy),  32'h0);
    check_eq("rst_done", 32'(irst_done),  32'h0);
    check_eq("rst_pass", 32'(pass_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch 0..4, then a branch of -2 from pc=4.
    fetch_en = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin branch_taken = 1; branch_offset = 6'b111110; end
      #1 check_eq("seq_pc", 32'(pc), 32'(i));
      #0 step();
    end
    branch_taken = 0;
    check_eq("branch_pc", 32'(pc), 32'h02);

    // Full sweep: limit 3, two write passes.
    fetch_en = 0; irst_limit = 3; irst_passes = 2; irst_start = 1;
    step();
    exp_seq.delete();
    for (int p = 0; p < 5; p++)
      for (int a = 0; a < 4; a++)
        exp_seq.push_back(((p % 2) == 1 ? 8'h80 : 8'h00) + a);
    foreach (exp_seq[k]) begin
      check_eq("sweep_pc", 32'(pc), 32'(exp_seq[k]));
      check_eq("sweep_we", 32'(write_en), 32'(exp_seq[k] >= 8'h80));
      step();
    end
    check_eq("sweep_done", 32'(irst_done), 32'h1);
    check_eq("sweep_pass", 32'(pass_count), 32'h2);
    step();
    irst_start = 0;
    step();
    check_eq("sweep_exit_busy", 32'(irst_busy | irst_done), 32'h0);

    // Reset asserted in the middle of a write sweep, between clock edges.
    irst_limit = 3; irst_passes = 2; irst_start = 1;
    for (int i = 0; i < 6; i++) step();
    check_eq("mis_we_before", 32'(write_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_we",   32'(write_en),  32'h0);
    check_eq("async_busy", 32'(irst_busy), 32'h0);
    check_eq("async_pc",   32'(pc),        32'h0);
    model_reset();
    irst_start = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_busy", 32'(irst_busy), 32'h0);

    // Advance to pc=0x25, then zero-pass sweep of two addresses, then exit.
    fetch_en = 1;
    for (int i = 0; i < 8'h25; i++) step();
    check_eq("pc_25", 32'(pc), 32'h25);
    fetch_en = 0; irst_limit = 1; irst_passes = 0; irst_start = 1;
    step();
    check_eq("zp_pc0", 32'(pc), 32'h00);
    check_eq("zp_we0", 32'(write_en), 32'h0);
    step();
    check_eq("zp_pc1", 32'(pc), 32'h01);
    check_eq("zp_we1", 32'(write_en), 32'h0);
    step();
    check_eq("zp_done", 32'(irst_done), 32'h1);
    irst_start = 0;
    step();
`ifdef IRST_SHADOW_PC_EN
    check_eq("restore_pc", 32'(pc), 32'h25);
`else
    check_eq("restore_pc", 32'(pc), 32'h00);
`endif

    // Wrap from 0xFF, then hold with fetch_en=0 and with stall=1.
    fetch_en = 1;
    for (int i = 0; i < 300 && m_pc != 8'hFF; i++) step();
    check_eq("pc_ff", 32'(pc), 32'hFF);
    step();
    check_eq("pc_wrap", 32'(pc), 32'h00);
    fetch_en = 0;
    step();
    check_eq("hold_noen", 32'(pc), 32'h00);
    fetch_en = 1; stall = 1;
    step();
    check_eq("hold_stall", 32'(pc), 32'h00);
    stall = 0;

    // Randomized run, including resets.
    do_reset();
    irst_limit = 7'($urandom_range(0, 5));
    irst_passes = 6'($urandom_range(0, 3));
    for (int i = 0; i < 4000; i++) begin
      stall         = ($urandom_range(0, 4) == 0);
      fetch_en      = $urandom_range(0, 1);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 6'($urandom);
      if ($urandom_range(0, 19) == 0) irst_start = ~irst_start;
      if ($urandom_range(0, 49) == 0) irst_limit = 7'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) irst_passes = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irst_fetch_unit.md
IRST_FETCH_UNIT -- requirements
Module: irst_fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, PC width in bits (minimum 4).
REQ-002 SHALL have parameter OFFSET_WIDTH, default 6, signed branch offset width (less than PC_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 6, pass-counter width.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  functional PC advance enable.
- stall  in  1  freezes PC/sweep address and state.
- branch_taken  in  1  take branch this cycle.
- branch_offset  in  OFFSET_WIDTH  signed PC-relative offset.
- irst_start  in  1  level request for the IRST sweep.
- irst_limit  in  PC_WIDTH-1  last sweep address (inclusive).
- irst_passes  in  CNT_WIDTH  number of write (MIS) sweeps.
- pc  out  PC_WIDTH  instruction-memory address.
- write_en  out  1  instruction-memory write strobe.
- irst_busy  out  1  high in FTI or MIS.
- irst_done  out  1  high in DONE.
- pass_count  out  CNT_WIDTH  completed MIS sweeps.

Function
REQ-005 SHALL implement four states: FUNC, FTI (read sweep), MIS (write sweep) and DONE.
REQ-006 In FUNC, SHALL compute next PC as pc_reg + sign-extended branch_offset when branch_taken=1, otherwise pc_reg+1, modulo 2^PC_WIDTH.
REQ-007 In FUNC, SHALL update pc_reg only when fetch_en=1 and stall=0, and SHALL otherwise hold it.
REQ-008 In FUNC, SHALL go FUNC->FTI on the edge where irst_start=1 and stall=0, and SHALL clear the sweep address and pass_count on that edge.
REQ-009 In FTI/MIS, SHALL increment the sweep address by 1 per cycle when stall=0, ignoring fetch_en, branch_taken and irst_start.
REQ-010 End of sweep is the cycle where sweep address == irst_limit and stall=0; the sweep address SHALL wrap to 0 on that edge.
REQ-011 At end of sweep in FTI, SHALL go to MIS when pass_count < irst_passes, otherwise to DONE.
REQ-012 At end of sweep in MIS, SHALL go to FTI and SHALL increment pass_count, saturating at all-ones.
REQ-013 In DONE, SHALL hold while irst_start=1 and SHALL go to FUNC when irst_start=0.
REQ-014 pc output SHALL be:
- pc_reg in FUNC and DONE.
- {0, sweep address} in FTI.
- {1, sweep address} in MIS.
REQ-015 write_en SHALL equal (state==MIS && stall==0), combinationally.
REQ-016 irst_busy and irst_done SHALL decode state combinationally.
REQ-017 Boundary cases:
- irst_passes=0: exactly one FTI sweep, then DONE with no write cycle.
- irst_limit=0: every sweep lasts one unstalled cycle.
REQ-018 stall=1 in any state SHALL freeze all registers; pc and pass_count hold their values and write_en=0.
REQ-019 irst_limit and irst_passes SHALL be sampled live each cycle; changing them mid-sweep takes effect on the next comparison.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=FUNC, pc_reg=0, sweep address=0, pass_count=0 and any shadow PC to 0, regardless of clk, including mid-sweep.
REQ-021 Consequently, during reset: pc=0, write_en=0, irst_busy=0, irst_done=0, pass_count=0.
REQ-022 On rst_n release, operation SHALL start on the next rising clk edge.

Configuration
REQ-023 Macro IRST_SHADOW_PC_EN.
- Defined: the FUNC->FTI edge SHALL save pc_reg into a shadow register, and the DONE->FUNC edge SHALL restore pc_reg from it.
- Undefined: the DONE->FUNC edge SHALL set pc_reg=0, and no shadow register SHALL exist.

Verification
REQ-024 Defaults, reset, fetch_en=1, 5 cycles: pc 0,1,2,3,4; branch_taken=1 with offset 6'b111110 at pc=4 -> pc=2 next cycle.
REQ-025 pc=8'hFF, fetch_en=1 -> pc=8'h00 (wrap); fetch_en=0 or stall=1 -> pc holds.
REQ-026 irst_limit=3, irst_passes=2, irst_start=1:
- pc sweeps 00-03, then 80-83 (write_en=1), then 00-03, 80-83, 00-03, then DONE.
- pass_count ends at 2; irst_done=1.
REQ-027 irst_passes=0, irst_limit=1 -> FTI pc 00,01, then DONE; write_en never asserted.
REQ-028 rst_n pulled low mid-MIS without a clock edge -> write_en, irst_busy and pc drop to 0 immediately; state=FUNC after release.
REQ-029 Shadow PC:
- IRST_SHADOW_PC_EN defined: enter IRST at pc=0x25, complete, drop irst_start -> pc=0x25 in FUNC.
- Undefined: same sequence -> pc=0x00.
